// File: rtl/fire2_squeeze_sched.sv
// fire2_squeeze_sched: sequences IFM reads, waits for the squeeze engine, then writes its DSP_NO results per pixel.
module fire2_squeeze_sched #(
  parameter int WOUT = 64,
  parameter int CHIN = 64,
  parameter int DSP_NO = 16,
  parameter int AW = 20,
  localparam int NPIX = WOUT * WOUT,
  localparam int PW = NPIX > 1 ? $clog2(NPIX) : 1,
  localparam int CW = CHIN > 1 ? $clog2(CHIN) : 1,
  localparam int KW = DSP_NO > 1 ? $clog2(DSP_NO) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ram_feedback,
  input  logic          fire2_squeeze_sample,
  output logic          ifm_rd_en,
  output logic [AW-1:0] ifm_addr,
  output logic          fire2_squeeze_en,
  output logic          ofm_wr_en,
  output logic [AW-1:0] ofm_addr,
  output logic [KW-1:0] ofm_sel,
  output logic          busy,
  output logic          fire2_squeeze_finish
);
  typedef enum logic [2:0] {IDLE, ACC, DRAIN, WAIT_S, WRITE, DONE} state_t;
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHIN - 1);
  localparam logic [KW-1:0] K_LAST = KW'(DSP_NO - 1);
  state_t state;
  logic [PW-1:0] pix;
  logic [CW-1:0] ch;
  logic [KW-1:0] k;
  logic [AW-1:0] rd_ptr, wr_ptr;
  // rd_ptr/wr_ptr walk pix*CHIN+ch and pix*DSP_NO+k linearly, so no multiplier is needed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pix <= '0;
      ch <= '0;
      k <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      ifm_rd_en <= 1'b0;
      ifm_addr <= '0;
      fire2_squeeze_en <= 1'b0;
      ofm_wr_en <= 1'b0;
      ofm_addr <= '0;
      ofm_sel <= '0;
      busy <= 1'b0;
      fire2_squeeze_finish <= 1'b0;
    end else begin
      fire2_squeeze_en <= ifm_rd_en;
      fire2_squeeze_finish <= 1'b0;
      ifm_rd_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ACC;
          busy <= 1'b1;
          pix <= '0;
          ch <= '0;
          k <= '0;
          rd_ptr <= '0;
          wr_ptr <= '0;
        end
        ACC: begin
          // while stalled, ifm_addr parks on the address about to be read
          ifm_addr <= rd_ptr;
          if (ram_feedback) begin
            ifm_rd_en <= 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
            ch <= ch == CH_LAST ? '0 : ch + 1'b1;
            if (ch == CH_LAST) state <= DRAIN;
          end
        end
        DRAIN: state <= WAIT_S;
        WAIT_S: if (fire2_squeeze_sample) begin
          state <= WRITE;
          ofm_wr_en <= 1'b1;
          ofm_addr <= wr_ptr;
          ofm_sel <= '0;
          wr_ptr <= wr_ptr + 1'b1;
          k <= '0;
        end
        WRITE: if (k == K_LAST) begin
          ofm_wr_en <= 1'b0;
          k <= '0;
          if (pix == PIX_LAST) begin
            state <= DONE;
            fire2_squeeze_finish <= 1'b1;
            busy <= 1'b0;
          end else begin
            pix <= pix + 1'b1;
            ch <= '0;
            state <= ACC;
          end
        end else begin
          k <= k + 1'b1;
          ofm_sel <= k + 1'b1;
          ofm_addr <= wr_ptr;
          wr_ptr <= wr_ptr + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fire2_squeeze_sched.sv
// tb_fire2_squeeze_sched: frame-level scoreboard for the squeeze scheduler, directed table rows plus random frames.
module tb_fire2_squeeze_sched;
  localparam int WOUT = 2, CHIN = 4, DSP_NO = 2, AW = 8, NPIX = WOUT * WOUT;
  logic clk = 1'b0, rst, start, ram_feedback, fire2_squeeze_sample;
  logic ifm_rd_en, fire2_squeeze_en, ofm_wr_en, busy, fire2_squeeze_finish;
  logic [AW-1:0] ifm_addr, ofm_addr;
  logic [0:0] ofm_sel;
  int n_cmp = 0, n_err = 0;
  int got_rd[$], got_wa[$], got_ws[$];
  typedef struct {
    int sdly; bit rnd; int stall_at; int stall_len; bit spur; int abort_wr; bit tail;
    int exp_rd; int exp_wr; int exp_fin;
  } vec_t;
  vec_t tbl[7];

  fire2_squeeze_sched #(.WOUT(WOUT), .CHIN(CHIN), .DSP_NO(DSP_NO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_feedback(ram_feedback),
    .fire2_squeeze_sample(fire2_squeeze_sample), .ifm_rd_en(ifm_rd_en), .ifm_addr(ifm_addr),
    .fire2_squeeze_en(fire2_squeeze_en), .ofm_wr_en(ofm_wr_en), .ofm_addr(ofm_addr),
    .ofm_sel(ofm_sel), .busy(busy), .fire2_squeeze_finish(fire2_squeeze_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({ifm_rd_en, ifm_addr, fire2_squeeze_en, ofm_wr_en, ofm_addr, ofm_sel, busy, fire2_squeeze_finish});
  endfunction

  task automatic run_frame(input vec_t v, input int tag);
    int cyc = 0, rd_pix = 0, d = -1, dly = 0, samp_cyc = -1, fin = 0, stall_left = v.stall_len;
    int en_err = 0, ex_err = 0, wait_err = 0, lat_err = 0, busy_err = 0, stall_err = 0, tail_err = 0, bad;
    bit prev_rd = ifm_rd_en, stall_now = 0, stall_prev = 0, waiting = 0, spur_done = 0, done = 0;
    int exp_rd[$], exp_wa[$], exp_ws[$];
    got_rd.delete(); got_wa.delete(); got_ws.delete();
    while (!done && cyc < 600) begin
      @(posedge clk); cyc++; #1;
      stall_prev = stall_now;
      stall_now = 0;
      start = (cyc == 1) || (v.rnd && $urandom_range(0, 9) == 0);
      ram_feedback = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_left > 0 && (got_rd.size() == v.stall_at - 1 || stall_left < v.stall_len)) begin
        ram_feedback = 1'b0;
        stall_left--;
        stall_now = 1;
      end
      fire2_squeeze_sample = 1'b0;
      if (waiting) fire2_squeeze_sample = (cyc == d + dly);
      else if (v.rnd && $urandom_range(0, 7) == 0) fire2_squeeze_sample = 1'b1;
      if (v.spur && !spur_done && got_rd.size() == 1) begin
        start = 1'b1;
        fire2_squeeze_sample = 1'b1;
        spur_done = 1;
      end
      if (waiting && fire2_squeeze_sample) samp_cyc = cyc;
      @(negedge clk);
      if (fire2_squeeze_en !== prev_rd) en_err++;
      prev_rd = ifm_rd_en;
      if (ifm_rd_en && ofm_wr_en) ex_err++;
      if (stall_prev && (ifm_rd_en || int'(ifm_addr) != v.stall_at)) stall_err++;
      if (cyc >= 2 && !fire2_squeeze_finish && !busy) busy_err++;
      if (fire2_squeeze_finish && busy) busy_err++;
      if (waiting && cyc > d && ifm_rd_en) wait_err++;
      if (ifm_rd_en) begin
        got_rd.push_back(int'(ifm_addr));
        if (++rd_pix == CHIN) begin
          rd_pix = 0;
          waiting = 1;
          d = cyc;
          dly = v.rnd ? int'($urandom_range(1, 6)) : v.sdly;
        end
      end
      if (ofm_wr_en) begin
        if (waiting && cyc != samp_cyc + 1) lat_err++;
        if (!waiting && got_ws.size() % DSP_NO == 0) lat_err++;
        waiting = 0;
        got_wa.push_back(int'(ofm_addr));
        got_ws.push_back(int'(ofm_sel));
        if (got_wa.size() == v.abort_wr) begin
          rst = 1'b1;
          #1 check($sformatf("abort_outs_async[%0d]", tag), outs(), 0);
          start = 1'b0;
          fire2_squeeze_sample = 1'b0;
          @(posedge clk); #1;
          check($sformatf("abort_outs_held[%0d]", tag), outs(), 0);
          @(negedge clk); rst = 1'b0;
          done = 1;
        end
      end
      if (fire2_squeeze_finish) begin
        fin++;
        done = 1;
      end
    end
    check($sformatf("frame_end_within_budget[%0d]", tag), int'(done), 1);
    if (v.tail) repeat (3) begin
      @(posedge clk); #1;
      start = 1'b0;
      fire2_squeeze_sample = 1'b0;
      @(negedge clk);
      if (fire2_squeeze_finish) fin++;
      if (ifm_rd_en || ofm_wr_en || busy) tail_err++;
    end
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < CHIN; c++) exp_rd.push_back(p * CHIN + c);
      for (int j = 0; j < DSP_NO; j++) begin
        exp_wa.push_back(p * DSP_NO + j);
        exp_ws.push_back(j);
      end
    end
    check($sformatf("rd_count[%0d]", tag), got_rd.size(), v.exp_rd);
    bad = 0;
    foreach (got_rd[i]) if (i >= exp_rd.size() || got_rd[i] != exp_rd[i]) bad++;
    check($sformatf("rd_addr_seq_bad[%0d]", tag), bad, 0);
    check($sformatf("wr_count[%0d]", tag), got_wa.size(), v.exp_wr);
    bad = 0;
    foreach (got_wa[i]) if (i >= exp_wa.size() || got_wa[i] != exp_wa[i] || got_ws[i] != exp_ws[i]) bad++;
    check($sformatf("wr_addr_sel_seq_bad[%0d]", tag), bad, 0);
    check($sformatf("finish_pulses[%0d]", tag), fin, v.exp_fin);
    check($sformatf("en_vs_rd_delay_err[%0d]", tag), en_err, 0);
    check($sformatf("rd_wr_overlap[%0d]", tag), ex_err, 0);
    check($sformatf("wait_strobe_err[%0d]", tag), wait_err, 0);
    check($sformatf("write_latency_err[%0d]", tag), lat_err, 0);
    check($sformatf("busy_err[%0d]", tag), busy_err, 0);
    if (v.stall_len > 0) check($sformatf("stall_hold_err[%0d]", tag), stall_err, 0);
    if (v.tail) check($sformatf("idle_after_done_err[%0d]", tag), tail_err, 0);
  endtask

  initial begin
    vec_t r;
    tbl[0] = '{3, 1'b0, -1, 0, 1'b0, -1, 1'b1, 16, 8, 1};
    tbl[1] = '{3, 1'b0, 6, 3, 1'b0, -1, 1'b1, 16, 8, 1};
    tbl[2] = '{20, 1'b0, -1, 0, 1'b0, -1, 1'b1, 16, 8, 1};
    tbl[3] = '{3, 1'b0, -1, 0, 1'b1, -1, 1'b1, 16, 8, 1};
    tbl[4] = '{3, 1'b0, -1, 0, 1'b0, 6, 1'b0, 12, 6, 0};
    tbl[5] = '{3, 1'b0, -1, 0, 1'b0, -1, 1'b0, 16, 8, 1};
    tbl[6] = '{3, 1'b0, -1, 0, 1'b0, -1, 1'b1, 16, 8, 1};
    rst = 1'b1;
    start = 1'b0;
    ram_feedback = 1'b0;
    fire2_squeeze_sample = 1'b0;
    repeat (3) @(posedge clk);
    start = 1'b1;
    ram_feedback = 1'b1;
    fire2_squeeze_sample = 1'b1;
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    start = 1'b0;
    fire2_squeeze_sample = 1'b0;
    @(posedge clk); #1;
    check("reset_ignores_inputs", outs(), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", outs(), 0);
    for (int i = 0; i < 7; i++) run_frame(tbl[i], i);
    r = '{0, 1'b1, -1, 0, 1'b0, -1, 1'b1, 16, 8, 1};
    for (int i = 0; i < 5; i++) run_frame(r, 100 + i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fire2_squeeze_sched.md
FIRE2_SQUEEZE_SCHED -- requirements
Module: fire2_squeeze_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WOUT, 64, output feature-map width and height (pixels per frame = WOUT*WOUT).
  CHIN, 64, input channels accumulated per pixel.
  DSP_NO, 16, output channels produced per pixel (one per DSP).
  AW, 20, width of both address buses.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single clock, rising edge.
  rst, in, 1, asynchronous active-high reset.
  start, in, 1, one-cycle pulse that launches one frame.
  ram_feedback, in, 1, IFM RAM ready; 0 stalls reads.
  fire2_squeeze_sample, in, 1, engine flag: DSP_NO results valid.
  ifm_rd_en, out, 1, IFM RAM read strobe.
  ifm_addr, out, AW, IFM read address.
  fire2_squeeze_en, out, 1, engine MAC enable, aligned with returned ifm data.
  ofm_wr_en, out, 1, OFM RAM write strobe.
  ofm_addr, out, AW, OFM write address.
  ofm_sel, out, clog2(DSP_NO), index of the engine ofm lane to write.
  busy, out, 1, high from the cycle after an accepted start until DONE.
  fire2_squeeze_finish, out, 1, one-cycle frame-complete pulse.

Function
REQ-003 The FSM SHALL have states IDLE, ACC, DRAIN, WAIT_S, WRITE and DONE.
REQ-004 IDLE->ACC SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-005 In ACC the block SHALL assert ifm_rd_en only when ram_feedback=1, with ifm_addr = pix*CHIN + ch.
REQ-006 Channel counter ch SHALL increment only on a cycle with ifm_rd_en=1.
REQ-007 When ram_feedback=0, ch and ifm_addr SHALL hold and ifm_rd_en SHALL be 0.
REQ-008 fire2_squeeze_en SHALL equal ifm_rd_en delayed by exactly one clock, for 1-cycle RAM read latency.
REQ-009 ACC->DRAIN SHALL occur on the cycle the read with ch=CHIN-1 is issued.
REQ-010 DRAIN SHALL last exactly one cycle, covering the final fire2_squeeze_en, then go to WAIT_S.
REQ-011 WAIT_S SHALL hold, with no strobes asserted, until fire2_squeeze_sample=1, then go to WRITE.
REQ-012 A fire2_squeeze_sample pulse outside WAIT_S SHALL be ignored.
REQ-013 WRITE SHALL run exactly DSP_NO cycles, each with ofm_wr_en=1, ofm_sel=k and ofm_addr = pix*DSP_NO + k, for k=0..DSP_NO-1.
REQ-014 After k=DSP_NO-1: if pix<WOUT*WOUT-1, pix SHALL increment, ch SHALL clear and the FSM SHALL go to ACC; otherwise it SHALL go to DONE.
REQ-015 DONE SHALL last one cycle, with fire2_squeeze_finish=1 and busy=0 the following cycle, then return to IDLE.
REQ-016 The pix, ch and k counters SHALL be wide enough for WOUT*WOUT-1, CHIN-1 and DSP_NO-1 without wrap.
REQ-017 Address products SHALL be computed by incrementing registers, with no multiplier, and truncated to AW bits.
REQ-018 ifm_rd_en and ofm_wr_en SHALL never be high in the same cycle.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 While rst=1, the FSM SHALL be in IDLE.
REQ-021 While rst=1, all counters SHALL be 0.
REQ-022 While rst=1, all outputs SHALL be 0, including both addresses, both strobes, ofm_sel, busy and fire2_squeeze_finish.
REQ-023 rst asserted mid-frame SHALL abort immediately with no further strobes, and the next start SHALL begin at pix=0, ch=0.

Verification (WOUT=2, CHIN=4, DSP_NO=2, AW=8)
REQ-024 Nominal frame: start with ram_feedback=1 and sample returned 3 cycles after DRAIN -> ifm_addr 0..15 read in 4 groups of 4, ofm_addr 0..7, exactly one fire2_squeeze_finish.
REQ-025 Read stall: ram_feedback=0 for 3 cycles at ch=2 of pix 1 -> ifm_addr holds at 6 with ifm_rd_en=0, resumes at 6, and fire2_squeeze_en shows no gap beyond the stall.
REQ-026 Late sample: sample withheld 20 cycles -> FSM stays in WAIT_S with all strobes 0, then WRITE starts the cycle after sample.
REQ-027 Spurious inputs: start pulse during ACC and sample pulse during ACC -> no effect on counters, addresses or strobe counts.
REQ-028 Reset mid-WRITE: rst at pix 2, k=1 -> all outputs 0 asynchronously, and a new start reproduces the REQ-024 trace.
REQ-029 Back-to-back frames: start 1 cycle after fire2_squeeze_finish -> second frame identical to the first.
